ram_fifo_controller: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of the full dual-port M10K RAM wrapper and drives both of its ports.
- Port A is used as the write port and port B as the read port.
- Presents valid/ready streams on both sides, with a first-word-fall-through output through a 2-entry prefetch buffer that absorbs the RAM's 1-cycle read latency at full throughput.

---
 rtl/memory_pkg.sv | 13 +
 rtl/fifo_prefetch_buffer.sv | 44 ++++
 rtl/ram_fifo_controller.sv | 102 ++++++++++
 tb/tb_ram_fifo_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared constants for the RAM-backed FIFO controller and its prefetch buffer.
package memory_pkg;

  localparam int RamReadLatency = 1;
  localparam int PrefetchSlots  = 2;

  // Width of a counter that can hold the RAM contents plus one in-flight read
  // and every prefetch slot.
  function automatic int CountWidth(input int depth);
    return $clog2(depth + PrefetchSlots + 1);
  endfunction

endpackage

// File: rtl/fifo_prefetch_buffer.sv
// Two-entry register FIFO that holds words returned by the RAM read port so the
// head of the queue is always available combinationally from registers.
module fifo_prefetch_buffer
  import memory_pkg::*;
#(
  parameter int Width = 8,
  localparam int SlotW = $clog2(PrefetchSlots + 1)
) (
  input  logic             ipClk,
  input  logic             ipReset,
  input  logic             ipPush,
  input  logic [Width-1:0] ipPushData,
  input  logic             ipPop,
  output logic [Width-1:0] opHeadData,
  output logic [SlotW-1:0] opCount
);

  logic [Width-1:0] r_mem [2];
  logic             r_head;
  logic             r_tail;
  logic [SlotW-1:0] r_count;

  // Storage is left unreset; the count alone decides what is valid.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= '0;
    end else begin
      if (ipPush) begin
        r_mem[r_tail] <= ipPushData;
        r_tail        <= ~r_tail;
      end
      if (ipPop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + SlotW'(ipPush) - SlotW'(ipPop);
    end
  end

  assign opHeadData = r_mem[r_head];
  assign opCount    = r_count;

endmodule

// File: rtl/ram_fifo_controller.sv
// FIFO controller driving a dual-port RAM (port A writes, port B reads) with a
// first-word-fall-through output fed by a small prefetch buffer.
module ram_fifo_controller
  import memory_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 1024,
  localparam int AW      = $clog2(Depth),
  localparam int CntW    = CountWidth(Depth),
  localparam int RamCntW = $clog2(Depth + 1)
) (
  input  logic             ipClk,
  input  logic             ipReset,
  input  logic [Width-1:0] ipWrData,
  input  logic             ipWrValid,
  output logic             opWrReady,
  output logic [Width-1:0] opRdData,
  output logic             opRdValid,
  input  logic             ipRdReady,
  output logic [CntW-1:0]  opCount,
  output logic             opRamClkEnable_A,
  output logic [AW-1:0]    opRamAddress_A,
  output logic [Width-1:0] opRamWrData_A,
  output logic             opRamWrEnable_A,
  output logic             opRamClkEnable_B,
  output logic [AW-1:0]    opRamAddress_B,
  output logic [Width-1:0] opRamWrData_B,
  output logic             opRamWrEnable_B,
  input  logic [Width-1:0] ipRamRdData_B
);

  logic [AW-1:0]      r_wrPtr;
  logic [AW-1:0]      r_rdPtr;
  logic [RamCntW-1:0] r_ramCount;
  logic               r_inflight;
  logic [CntW-1:0]    r_count;

  logic               w_wrFire;
  logic               w_rdIssue;
  logic               w_pop;
  logic [1:0]         w_bufCount;

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] ptr);
    return (ptr == AW'(Depth - 1)) ? '0 : ptr + AW'(1);
  endfunction

  assign opWrReady = !ipReset && (r_ramCount < RamCntW'(Depth));
  assign w_wrFire  = ipWrValid && opWrReady;
  assign opRdValid = (w_bufCount != 2'd0);
  assign w_pop     = opRdValid && ipRdReady;

  // A read is launched only when its word is guaranteed a buffer slot on
  // arrival, counting the slot freed by a pop happening this same cycle.
  assign w_rdIssue = !ipReset && (r_ramCount != '0) &&
                     (({1'b0, w_bufCount} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  assign opRamClkEnable_A = w_wrFire;
  assign opRamWrEnable_A  = w_wrFire;
  assign opRamAddress_A   = r_wrPtr;
  assign opRamWrData_A    = ipWrData;

  assign opRamClkEnable_B = w_rdIssue;
  assign opRamAddress_B   = r_rdPtr;
  assign opRamWrData_B    = '0;
  assign opRamWrEnable_B  = 1'b0;

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_ramCount <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_wrFire) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (w_rdIssue) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      r_ramCount <= r_ramCount + RamCntW'(w_wrFire) - RamCntW'(w_rdIssue);
      r_inflight <= w_rdIssue;
      // Total occupancy only changes at the two stream handshakes.
      r_count    <= r_count + CntW'(w_wrFire) - CntW'(w_pop);
    end
  end

  assign opCount = r_count;

  fifo_prefetch_buffer #(
    .Width(Width)
  ) u_buffer (
    .ipClk      (ipClk),
    .ipReset    (ipReset),
    .ipPush     (r_inflight),
    .ipPushData (ipRamRdData_B),
    .ipPop      (w_pop),
    .opHeadData (opRdData),
    .opCount    (w_bufCount)
  );

endmodule

// File: tb/tb_ram_fifo_controller.sv
// Scoreboard bench for ram_fifo_controller with a small Depth so that wrap and
// full conditions are reached quickly; includes a behavioural dual-port RAM.
module tb_ram_fifo_controller;

  localparam int Width = 8;
  localparam int Depth = 5;
  localparam int AW    = $clog2(Depth);
  localparam int CntW  = $clog2(Depth + 3);

  logic             ipClk = 1'b0;
  logic             ipReset;
  logic [Width-1:0] ipWrData;
  logic             ipWrValid;
  logic             opWrReady;
  logic [Width-1:0] opRdData;
  logic             opRdValid;
  logic             ipRdReady;
  logic [CntW-1:0]  opCount;
  logic             opRamClkEnable_A;
  logic [AW-1:0]    opRamAddress_A;
  logic [Width-1:0] opRamWrData_A;
  logic             opRamWrEnable_A;
  logic             opRamClkEnable_B;
  logic [AW-1:0]    opRamAddress_B;
  logic [Width-1:0] opRamWrData_B;
  logic             opRamWrEnable_B;
  logic [Width-1:0] ipRamRdData_B;

  int compared   = 0;
  int mismatched = 0;

  logic [Width-1:0] expQ[$];
  int mCount, mWrPtr, mRdPtr, mWritten, mIssued, mPopped;
  int popCount = 0;

  ram_fifo_controller #(
    .Width(Width),
    .Depth(Depth)
  ) dut (
    .ipClk            (ipClk),
    .ipReset          (ipReset),
    .ipWrData         (ipWrData),
    .ipWrValid        (ipWrValid),
    .opWrReady        (opWrReady),
    .opRdData         (opRdData),
    .opRdValid        (opRdValid),
    .ipRdReady        (ipRdReady),
    .opCount          (opCount),
    .opRamClkEnable_A (opRamClkEnable_A),
    .opRamAddress_A   (opRamAddress_A),
    .opRamWrData_A    (opRamWrData_A),
    .opRamWrEnable_A  (opRamWrEnable_A),
    .opRamClkEnable_B (opRamClkEnable_B),
    .opRamAddress_B   (opRamAddress_B),
    .opRamWrData_B    (opRamWrData_B),
    .opRamWrEnable_B  (opRamWrEnable_B),
    .ipRamRdData_B    (ipRamRdData_B)
  );

  always #5 ipClk = ~ipClk;

  // Behavioural M10K: registered address, q appears the cycle after the read.
  logic [Width-1:0] ramMem [Depth];
  always @(posedge ipClk) begin
    if (opRamClkEnable_A && opRamWrEnable_A) ramMem[opRamAddress_A] <= opRamWrData_A;
    if (opRamClkEnable_B) ipRamRdData_B <= ramMem[opRamAddress_B];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic wrValid, input logic [Width-1:0] wrData,
                               input logic rdReady);
    @(posedge ipClk);
    #1;
    ipReset   = 1'b0;
    ipWrValid = wrValid;
    ipWrData  = wrData;
    ipRdReady = rdReady;
  endtask

  task automatic applyReset();
    @(posedge ipClk);
    #1;
    ipReset   = 1'b1;
    ipWrValid = 1'b0;
    ipRdReady = 1'b0;
    @(negedge ipClk);
    checkOutput("wrReadyInReset", {31'b0, opWrReady}, 0);
  endtask

  task automatic drain(input int maxCycles);
    int n = 0;
    while ((expQ.size() != 0 || mCount != 0) && n < maxCycles) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    checkOutput("drainComplete", expQ.size(), 0);
  endtask

  // Monitor: the model is a queue of accepted words plus simple counters of
  // writes, issued reads and pops; the RAM pointers are those counts mod Depth.
  initial begin
    forever begin
      @(negedge ipClk);
      if (ipReset) begin
        expQ.delete();
        mCount = 0; mWrPtr = 0; mRdPtr = 0;
        mWritten = 0; mIssued = 0; mPopped = 0;
      end else begin
        automatic logic pop  = opRdValid && ipRdReady;
        automatic logic fire = ipWrValid && opWrReady;
        checkOutput("count", opCount, mCount);
        if (pop) begin
          if (expQ.size() == 0) begin
            checkOutput("popWithEmptyModel", 1, 0);
          end else begin
            checkOutput("rdData", opRdData, expQ.pop_front());
          end
          mPopped++;
          popCount++;
        end
        if (opRamClkEnable_B) begin
          checkOutput("rdAddr", opRamAddress_B, mRdPtr);
          checkOutput("issueOccupied", {31'b0, mIssued < mWritten}, 1);
          mIssued++;
          checkOutput("issueCapacity", {31'b0, (mIssued - mPopped) <= 2}, 1);
          mRdPtr = (mRdPtr + 1) % Depth;
        end
        if (fire) begin
          checkOutput("wrEnA", {31'b0, opRamWrEnable_A && opRamClkEnable_A}, 1);
          checkOutput("wrAddr", opRamAddress_A, mWrPtr);
          checkOutput("wrDataA", opRamWrData_A, ipWrData);
          expQ.push_back(ipWrData);
          mWrPtr = (mWrPtr + 1) % Depth;
          mWritten++;
        end else begin
          checkOutput("wrEnIdle", {31'b0, opRamWrEnable_A}, 0);
        end
        mCount = mCount + int'(fire) - int'(pop);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    ipReset = 1'b1; ipWrValid = 1'b0; ipWrData = '0; ipRdReady = 1'b0;
    repeat (3) @(posedge ipClk);

    // Reset values
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge ipClk);
    checkOutput("rstValid", {31'b0, opRdValid}, 0);
    checkOutput("rstCount", opCount, 0);
    checkOutput("rstWrReady", {31'b0, opWrReady}, 1);
    checkOutput("portBWrEn", {31'b0, opRamWrEnable_B}, 0);
    checkOutput("portBWrData", opRamWrData_B, 0);

    // Single-word latency
    applyStimulus(1'b1, 8'hA5, 1'b1);
    @(negedge ipClk);
    checkOutput("latWrEn", {31'b0, opRamWrEnable_A}, 1);
    checkOutput("latWrAddr", opRamAddress_A, 0);
    checkOutput("latCountW", opCount, 0);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge ipClk);
    checkOutput("latRdEn", {31'b0, opRamClkEnable_B}, 1);
    checkOutput("latRdAddr", opRamAddress_B, 0);
    checkOutput("latCountW1", opCount, 1);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge ipClk);
    checkOutput("latValidW2", {31'b0, opRdValid}, 0);
    checkOutput("latCountW2", opCount, 1);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge ipClk);
    checkOutput("latValidW3", {31'b0, opRdValid}, 1);
    checkOutput("latDataW3", opRdData, 8'hA5);
    checkOutput("latCountW3", opCount, 1);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge ipClk);
    checkOutput("latCountW4", opCount, 0);
    checkOutput("latValidW4", {31'b0, opRdValid}, 0);

    // Fill to capacity: Depth words in RAM plus two in the buffer
    for (int i = 0; i < Depth + 2; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
      checkOutput("fillWrReady", {31'b0, opWrReady}, 1);
    end
    applyStimulus(1'b1, 8'hEE, 1'b0);
    @(negedge ipClk);
    checkOutput("fullWrReady", {31'b0, opWrReady}, 0);
    checkOutput("fullCount", opCount, Depth + 2);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge ipClk);
    checkOutput("fullCountHeld", opCount, Depth + 2);
    drain(40);

    // Continuous stream with both sides always ready
    begin
      int i = 0;
      int cycles = 0;
      int startPops = popCount;
      while (popCount - startPops < 100 && cycles < 300) begin
        applyStimulus(i < 100, 8'(i), 1'b1);
        if (i < 100 && opWrReady) i++;
        cycles++;
      end
      checkOutput("streamPops", popCount - startPops, 100);
      checkOutput("streamThroughput", {31'b0, cycles <= 106}, 1);
    end
    drain(20);

    // Random traffic with 50% read backpressure
    begin
      int accepted = 0;
      int cycles = 0;
      while (accepted < 1000 && cycles < 10000) begin
        applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), 1'($urandom_range(0, 1)));
        if (ipWrValid && opWrReady) accepted++;
        cycles++;
      end
      checkOutput("randomAccepted", accepted, 1000);
    end
    drain(40);

    // Reset with three words stored and a read in flight
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    applyReset();
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge ipClk);
    checkOutput("postRstValid", {31'b0, opRdValid}, 0);
    checkOutput("postRstCount", opCount, 0);
    checkOutput("postRstWrReady", {31'b0, opWrReady}, 1);
    applyStimulus(1'b1, 8'h11, 1'b1);
    begin
      int n = 0;
      do begin
        applyStimulus(1'b0, '0, 1'b1);
        n++;
      end while (!opRdValid && n < 10);
      checkOutput("postRstFirstWord", opRdData, 8'h11);
    end
    drain(10);

    // Reading from an empty FIFO
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      @(negedge ipClk);
      checkOutput("emptyRdEn", {31'b0, opRamClkEnable_B}, 0);
      checkOutput("emptyValid", {31'b0, opRdValid}, 0);
    end

    applyStimulus(1'b0, '0, 1'b0);
    @(negedge ipClk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
